// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-boundary register with valid/ready handshake, flush,
// optional 2-entry skid buffer and a saturating stall counter.
module pipe_stage_reg #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 4,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam bit              USE_SKID = (SKID != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              main_valid_r, main_valid_s;
  logic [CTRL_W-1:0] main_ctrl_r,  main_ctrl_s;
  logic [DATA_W-1:0] main_data_r,  main_data_s;
  logic              skid_valid_r, skid_valid_s;
  logic [CTRL_W-1:0] skid_ctrl_r,  skid_ctrl_s;
  logic [DATA_W-1:0] skid_data_r,  skid_data_s;
  logic [CNT_W-1:0]  cnt_r,        cnt_s;
  logic              accept_s, main_free_s, held_s;

  // Skid mode exposes only registered state on in_ready.
  generate
    if (USE_SKID) begin : g_ready_skid
      assign in_ready = ~skid_valid_r;
    end else begin : g_ready_comb
      assign in_ready = out_ready | ~main_valid_r;
    end
  endgenerate

  assign accept_s    = in_valid & in_ready;
  assign main_free_s = ~main_valid_r | out_ready;
  assign held_s      = main_valid_r & ~out_ready;

  // Next-state selection for the main and skid entries.
  always_comb begin
    main_valid_s = main_valid_r;
    main_ctrl_s  = main_ctrl_r;
    main_data_s  = main_data_r;
    skid_valid_s = skid_valid_r;
    skid_ctrl_s  = skid_ctrl_r;
    skid_data_s  = skid_data_r;
    if (flush) begin
      // A beat accepted this cycle is dropped along with everything held.
      main_valid_s = 1'b0;
      main_ctrl_s  = {CTRL_W{1'b0}};
      skid_valid_s = 1'b0;
      skid_ctrl_s  = {CTRL_W{1'b0}};
    end else if (main_free_s) begin
      if (skid_valid_r) begin
        main_valid_s = 1'b1;
        main_ctrl_s  = skid_ctrl_r;
        main_data_s  = skid_data_r;
        skid_valid_s = accept_s;
        if (accept_s) begin
          skid_ctrl_s = in_ctrl;
          skid_data_s = in_data;
        end else begin
          skid_ctrl_s = {CTRL_W{1'b0}};
        end
      end else if (accept_s) begin
        main_valid_s = 1'b1;
        main_ctrl_s  = in_ctrl;
        main_data_s  = in_data;
      end else begin
        main_valid_s = 1'b0;
        main_ctrl_s  = {CTRL_W{1'b0}};
      end
    end else begin
      if (accept_s && USE_SKID) begin
        skid_valid_s = 1'b1;
        skid_ctrl_s  = in_ctrl;
        skid_data_s  = in_data;
      end else begin
        skid_valid_s = skid_valid_r;
      end
    end
  end

  // Saturating count of downstream-stalled cycles.
  always_comb begin
    if (held_s && (cnt_r != CNT_MAX)) begin
      cnt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_s = cnt_r;
    end
  end

  // State registers; reset wins over flush and handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_r <= 1'b0;
      main_ctrl_r  <= {CTRL_W{1'b0}};
      main_data_r  <= {DATA_W{1'b0}};
      skid_valid_r <= 1'b0;
      skid_ctrl_r  <= {CTRL_W{1'b0}};
      skid_data_r  <= {DATA_W{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
    end else begin
      main_valid_r <= main_valid_s;
      main_ctrl_r  <= main_ctrl_s;
      main_data_r  <= main_data_s;
      skid_valid_r <= skid_valid_s;
      skid_ctrl_r  <= skid_ctrl_s;
      skid_data_r  <= skid_data_s;
      cnt_r        <= cnt_s;
    end
  end

  assign out_valid = main_valid_r;
  assign out_ctrl  = main_ctrl_r;
  assign out_data  = main_data_r;
  assign stall_cnt = cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: u0 is the combinational-ready stage with a 4-bit counter,
// u1 the skid-buffered stage with the default 16-bit counter.
module tb_pipe_stage_reg;

  typedef struct {
    logic [3:0]   c;
    logic [100:0] d;
  } beat_t;

  logic clk;
  int n_checks = 0;
  int n_pass   = 0;
  beat_t q0[$];
  beat_t q1[$];

  logic         rst0, flush0, iv0, ir0, ov0, or0;
  logic [3:0]   ic0, oc0, cnt0;
  logic [100:0] id0, od0;
  logic         rst1, flush1, iv1, ir1, ov1, or1;
  logic [3:0]   ic1, oc1;
  logic [15:0]  cnt1;
  logic [100:0] id1, od1;

  pipe_stage_reg #(.DATA_W(101), .CTRL_W(4), .SKID(0), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst0), .flush(flush0), .in_valid(iv0), .in_ready(ir0),
    .in_ctrl(ic0), .in_data(id0), .out_valid(ov0), .out_ready(or0),
    .out_ctrl(oc0), .out_data(od0), .stall_cnt(cnt0));

  pipe_stage_reg #(.DATA_W(101), .CTRL_W(4), .SKID(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst1), .flush(flush1), .in_valid(iv1), .in_ready(ir1),
    .in_ctrl(ic1), .in_data(id1), .out_valid(ov1), .out_ready(or1),
    .out_ctrl(oc1), .out_data(od1), .stall_cnt(cnt1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t mk(input logic [3:0] c, input logic [100:0] d);
    beat_t b;
    b.c = c;
    b.d = d;
    return b;
  endfunction

  // Monitor for u0: bubbles carry zero ctrl, emitted beats match the queue.
  always @(negedge clk) begin
    if (rst0 === 1'b0) begin
      if (ov0 === 1'b0) chk("bubble_ctrl0", {124'd0, oc0}, 128'd0);
      if (ov0 === 1'b1 && or0 === 1'b1) begin
        if (q0.size() == 0) begin
          chk("unexpected_beat0", {27'd0, od0}, 128'd0 - 128'd1);
        end else begin
          beat_t e;
          e = q0.pop_front();
          chk("beat_data0", {27'd0, od0}, {27'd0, e.d});
          chk("beat_ctrl0", {124'd0, oc0}, {124'd0, e.c});
        end
      end
    end
  end

  // Monitor for u1.
  always @(negedge clk) begin
    if (rst1 === 1'b0) begin
      if (ov1 === 1'b0) chk("bubble_ctrl1", {124'd0, oc1}, 128'd0);
      if (ov1 === 1'b1 && or1 === 1'b1) begin
        if (q1.size() == 0) begin
          chk("unexpected_beat1", {27'd0, od1}, 128'd0 - 128'd1);
        end else begin
          beat_t e;
          e = q1.pop_front();
          chk("beat_data1", {27'd0, od1}, {27'd0, e.d});
          chk("beat_ctrl1", {124'd0, oc1}, {124'd0, e.c});
        end
      end
    end
  end

  initial begin
    rst0 = 1'b1; flush0 = 1'b0; iv0 = 1'b0; ic0 = 4'h0; id0 = 101'd0; or0 = 1'b0;
    rst1 = 1'b1; flush1 = 1'b0; iv1 = 1'b0; ic1 = 4'h0; id1 = 101'd0; or1 = 1'b0;
    tick();
    rst0 = 1'b0; rst1 = 1'b0;
    chk("rst_ov0", {127'd0, ov0}, 128'd0);
    chk("rst_oc0", {124'd0, oc0}, 128'd0);
    chk("rst_od0", {27'd0, od0}, 128'd0);
    chk("rst_cnt0", {124'd0, cnt0}, 128'd0);
    chk("rst_ir0", {127'd0, ir0}, 128'd1);
    chk("rst_ov1", {127'd0, ov1}, 128'd0);
    chk("rst_od1", {27'd0, od1}, 128'd0);
    chk("rst_cnt1", {112'd0, cnt1}, 128'd0);
    chk("rst_ir1", {127'd0, ir1}, 128'd1);

    // Stream 8 beats through both stages at full rate.
    for (int i = 0; i < 8; i++) begin
      q0.push_back(mk(4'hF, 101'(i)));
      q1.push_back(mk(4'hF, 101'(i)));
    end
    or0 = 1'b1; or1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      iv0 = 1'b1; ic0 = 4'hF; id0 = 101'(i);
      iv1 = 1'b1; ic1 = 4'hF; id1 = 101'(i);
      tick();
      chk("stream_ov0", {127'd0, ov0}, 128'd1);
      chk("stream_od0", {27'd0, od0}, 128'(i));
      chk("stream_ov1", {127'd0, ov1}, 128'd1);
      chk("stream_od1", {27'd0, od1}, 128'(i));
    end
    iv0 = 1'b0; iv1 = 1'b0;
    tick();
    chk("stream_drain_ov0", {127'd0, ov0}, 128'd0);
    chk("stream_drain_ov1", {127'd0, ov1}, 128'd0);
    chk("stream_cnt0", {124'd0, cnt0}, 128'd0);
    chk("stream_cnt1", {112'd0, cnt1}, 128'd0);

    // Backpressure on the skid stage: A held, B to skid, C stalled.
    q1.push_back(mk(4'h1, 101'h1A));
    q1.push_back(mk(4'h2, 101'h1B));
    q1.push_back(mk(4'h3, 101'h1C));
    or1 = 1'b0; iv1 = 1'b1; ic1 = 4'h1; id1 = 101'h1A;
    tick();
    chk("bp_ir_after_a", {127'd0, ir1}, 128'd1);
    ic1 = 4'h2; id1 = 101'h1B;
    tick();
    chk("bp_ir_after_b", {127'd0, ir1}, 128'd0);
    chk("bp_cnt_1", {112'd0, cnt1}, 128'd1);
    ic1 = 4'h3; id1 = 101'h1C;
    tick();
    tick();
    chk("bp_ir_stalled", {127'd0, ir1}, 128'd0);
    chk("bp_hold_data", {27'd0, od1}, 128'h1A);
    chk("bp_hold_ctrl", {124'd0, oc1}, 128'h1);
    chk("bp_cnt_3", {112'd0, cnt1}, 128'd3);
    or1 = 1'b1;
    tick();
    chk("bp_main_b", {27'd0, od1}, 128'h1B);
    chk("bp_ir_free", {127'd0, ir1}, 128'd1);
    tick();
    chk("bp_main_c", {27'd0, od1}, 128'h1C);
    iv1 = 1'b0;
    tick();
    chk("bp_drain_ov", {127'd0, ov1}, 128'd0);
    chk("bp_cnt_final", {112'd0, cnt1}, 128'd3);

    // Flush the skid stage while main and skid are both full.
    q1.push_back(mk(4'h4, 101'h1D));
    or1 = 1'b0; iv1 = 1'b1; ic1 = 4'h5; id1 = 101'h2A;
    tick();
    ic1 = 4'h6; id1 = 101'h2B;
    tick();
    chk("fl_full_ir", {127'd0, ir1}, 128'd0);
    ic1 = 4'h7; id1 = 101'h2C; flush1 = 1'b1;
    tick();
    flush1 = 1'b0;
    chk("fl_ov", {127'd0, ov1}, 128'd0);
    chk("fl_oc", {124'd0, oc1}, 128'd0);
    chk("fl_ir", {127'd0, ir1}, 128'd1);
    chk("fl_od_kept", {27'd0, od1}, 128'h2A);
    chk("fl_cnt", {112'd0, cnt1}, 128'd5);
    ic1 = 4'h4; id1 = 101'h1D; or1 = 1'b1;
    tick();
    chk("fl_d_out", {27'd0, od1}, 128'h1D);
    iv1 = 1'b0;
    tick();
    tick();
    chk("fl_idle_ov", {127'd0, ov1}, 128'd0);

    // Simultaneous emit and flush on the combinational-ready stage.
    q0.push_back(mk(4'h8, 101'h30));
    iv0 = 1'b1; ic0 = 4'h8; id0 = 101'h30; or0 = 1'b1;
    tick();
    chk("ef_ov_before", {127'd0, ov0}, 128'd1);
    ic0 = 4'h9; id0 = 101'h31; flush0 = 1'b1;
    tick();
    flush0 = 1'b0; iv0 = 1'b0;
    chk("ef_ov", {127'd0, ov0}, 128'd0);
    chk("ef_oc", {124'd0, oc0}, 128'd0);
    chk("ef_ir", {127'd0, ir0}, 128'd1);
    tick();
    tick();
    chk("ef_idle_ov", {127'd0, ov0}, 128'd0);

    // Counter saturation with a 4-bit counter.
    iv0 = 1'b1; ic0 = 4'hA; id0 = 101'h40; or0 = 1'b1;
    tick();
    iv0 = 1'b0; or0 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("sat_cnt", {124'd0, cnt0}, (i + 1 > 15) ? 128'd15 : 128'(i + 1));
    end
    chk("sat_hold_data", {27'd0, od0}, 128'h40);
    chk("sat_hold_ctrl", {124'd0, oc0}, 128'hA);
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    chk("sat_rst_cnt", {124'd0, cnt0}, 128'd0);
    chk("sat_rst_ov", {127'd0, ov0}, 128'd0);

    // Synchronous reset with main and skid full.
    or1 = 1'b0; iv1 = 1'b1; ic1 = 4'hB; id1 = 101'h50;
    tick();
    ic1 = 4'hC; id1 = 101'h51;
    tick();
    iv1 = 1'b0;
    rst1 = 1'b1;
    @(negedge clk);
    chk("rst_mid_ov_hold", {127'd0, ov1}, 128'd1);
    chk("rst_mid_od_hold", {27'd0, od1}, 128'h50);
    chk("rst_mid_ir_hold", {127'd0, ir1}, 128'd0);
    chk("rst_mid_cnt_hold", {112'd0, cnt1}, 128'd6);
    tick();
    rst1 = 1'b0;
    chk("rst_mid_ov", {127'd0, ov1}, 128'd0);
    chk("rst_mid_oc", {124'd0, oc1}, 128'd0);
    chk("rst_mid_od", {27'd0, od1}, 128'd0);
    chk("rst_mid_cnt", {112'd0, cnt1}, 128'd0);
    chk("rst_mid_ir", {127'd0, ir1}, 128'd1);
    q1.push_back(mk(4'hD, 101'h60));
    iv1 = 1'b1; ic1 = 4'hD; id1 = 101'h60; or1 = 1'b1;
    tick();
    iv1 = 1'b0;
    tick();
    tick();
    chk("rst_after_ov", {127'd0, ov1}, 128'd0);

    chk("q0_empty", 128'(q0.size()), 128'd0);
    chk("q1_empty", 128'(q1.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
